// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing SRAM port 0 between requesters A and B, with an
// optional post-reset pass that writes INIT_VALUE to every word.
module sram_port_arbiter #(
  parameter int                ADDR_W        = 9,
  parameter int                DATA_W        = 32,
  parameter int                MASK_W        = 4,
  parameter bit                INIT_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
  input  logic              clk0,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [MASK_W-1:0] a_wmask,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [MASK_W-1:0] b_wmask,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [MASK_W-1:0] sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [DATA_W-1:0] sram_din0,
  input  logic [DATA_W-1:0] sram_dout0,
  output logic              init_done
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] init_addr, init_addr_next;
  logic              rr_ptr, rr_ptr_next;  // 0 = A has priority, 1 = B
  logic              init_done_next;

  logic              cmd_csb, cmd_web;
  logic [MASK_W-1:0] cmd_wmask;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_din;

  // Two-stage read tag: stage 0 tracks the command on the pins, stage 1 the
  // cycle in which the SRAM output holds its data.
  logic [1:0]        tag_valid, tag_owner;
  logic              tag_valid_next, tag_owner_next;

  always_comb begin
    state_next     = state;
    init_addr_next = init_addr;
    rr_ptr_next    = rr_ptr;
    init_done_next = init_done;
    a_gnt          = 1'b0;
    b_gnt          = 1'b0;
    cmd_csb        = 1'b1;
    cmd_web        = 1'b1;
    cmd_wmask      = sram_wmask0;
    cmd_addr       = sram_addr0;
    cmd_din        = sram_din0;
    tag_valid_next = 1'b0;
    tag_owner_next = 1'b0;

    case (state)
      ST_INIT: begin
        if (INIT_ON_RESET) begin
          cmd_csb        = 1'b0;
          cmd_web        = 1'b0;
          cmd_wmask      = '1;
          cmd_addr       = init_addr;
          cmd_din        = INIT_VALUE;
          init_addr_next = init_addr + ADDR_W'(1);
          if (init_addr == '1) begin
            state_next     = ST_RUN;
            init_done_next = 1'b1;
          end
        end else begin
          state_next     = ST_RUN;
          init_done_next = 1'b1;
        end
      end
      ST_RUN: begin
        a_gnt = a_req & (~b_req | ~rr_ptr);
        b_gnt = b_req & ~a_gnt;
        if (a_gnt) begin
          cmd_csb        = 1'b0;
          cmd_web        = ~a_we;
          cmd_wmask      = a_we ? a_wmask : '0;
          cmd_addr       = a_addr;
          cmd_din        = a_wdata;
          rr_ptr_next    = 1'b1;
          tag_valid_next = ~a_we;
          tag_owner_next = 1'b0;
        end else if (b_gnt) begin
          cmd_csb        = 1'b0;
          cmd_web        = ~b_we;
          cmd_wmask      = b_we ? b_wmask : '0;
          cmd_addr       = b_addr;
          cmd_din        = b_wdata;
          rr_ptr_next    = 1'b0;
          tag_valid_next = ~b_we;
          tag_owner_next = 1'b1;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      state       <= ST_INIT;
      init_addr   <= '0;
      rr_ptr      <= 1'b0;
      init_done   <= 1'b0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      tag_valid   <= '0;
      tag_owner   <= '0;
    end else begin
      state       <= state_next;
      init_addr   <= init_addr_next;
      rr_ptr      <= rr_ptr_next;
      init_done   <= init_done_next;
      sram_csb0   <= cmd_csb;
      sram_web0   <= cmd_web;
      sram_wmask0 <= cmd_wmask;
      sram_addr0  <= cmd_addr;
      sram_din0   <= cmd_din;
      tag_valid   <= {tag_valid[0], tag_valid_next};
      tag_owner   <= {tag_owner[0], tag_owner_next};
    end
  end

  assign a_rvalid = tag_valid[1] & ~tag_owner[1];
  assign b_rvalid = tag_valid[1] &  tag_owner[1];
  assign a_rdata  = sram_dout0;
  assign b_rdata  = sram_dout0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised and directed bench for sram_port_arbiter: a word-level memory and
// request-rule model predicts grants, SRAM pins and read returns every cycle.
module tb_sram_port_arbiter;
  localparam int          DEPTH      = 512;
  localparam logic [31:0] INIT_VALUE = 32'h0;

  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [3:0]  a_wmask, b_wmask;
  logic [8:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        sram_csb0, sram_web0, init_done;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0, sram_dout0;

  sram_port_arbiter #(.INIT_ON_RESET(1'b1), .INIT_VALUE(INIT_VALUE)) dut (
    .clk0(clk0), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_wmask(a_wmask), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_wmask(b_wmask), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .init_done(init_done)
  );

  // Second instance with the initialise pass disabled.
  logic        rst2, a_req2, b_req2;
  logic        a_gnt2, a_rvalid2, b_gnt2, b_rvalid2;
  logic [31:0] a_rdata2, b_rdata2;
  logic        csb2, web2, init_done2;
  logic [3:0]  wmask2;
  logic [8:0]  addr2;
  logic [31:0] din2, dout2;

  sram_port_arbiter #(.INIT_ON_RESET(1'b0)) dut2 (
    .clk0(clk0), .rst(rst2),
    .a_req(a_req2), .a_we(1'b0), .a_wmask(4'h0), .a_addr(9'd3), .a_wdata(32'h0),
    .a_gnt(a_gnt2), .a_rvalid(a_rvalid2), .a_rdata(a_rdata2),
    .b_req(b_req2), .b_we(1'b0), .b_wmask(4'h0), .b_addr(9'd0), .b_wdata(32'h0),
    .b_gnt(b_gnt2), .b_rvalid(b_rvalid2), .b_rdata(b_rdata2),
    .sram_csb0(csb2), .sram_web0(web2), .sram_wmask0(wmask2),
    .sram_addr0(addr2), .sram_din0(din2), .sram_dout0(dout2),
    .init_done(init_done2)
  );

  // Behavioural SRAM macros: capture on the rising edge, registered read.
  logic [31:0] sram_mem [DEPTH];
  logic [31:0] mem2 [DEPTH];
  always @(posedge clk0) begin
    logic [31:0] w;
    if (!sram_csb0) begin
      if (!sram_web0) begin
        w = sram_mem[sram_addr0];
        for (int i = 0; i < 4; i++)
          if (sram_wmask0[i]) w[8*i +: 8] = sram_din0[8*i +: 8];
        sram_mem[sram_addr0] <= w;
      end else begin
        sram_dout0 <= sram_mem[sram_addr0];
      end
    end
    if (!csb2 && web2) dout2 <= mem2[addr2];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model
  typedef struct { int due; bit owner; logic [31:0] data; } rv_t;
  rv_t         rvq[$];
  logic [31:0] mem_m [DEPTH];
  bit          m_run, m_rr, a_acc_m, b_acc_m;
  int          m_init_cnt;
  int          e_mode;  // 0 reset values, 1 idle, 2 write, 3 read
  logic [8:0]  e_addr;
  logic [3:0]  e_mask;
  logic [31:0] e_din;

  task automatic model_reset();
    m_run = 0; m_rr = 0; m_init_cnt = 0; e_mode = 0;
    a_acc_m = 0; b_acc_m = 0;
    rvq.delete();
  endtask

  initial model_reset();

  always @(negedge clk0) begin
    logic eg_a, eg_b, exp_rva, exp_rvb, o_we;
    logic [31:0] exp_rd, o_data;
    logic [8:0]  o_addr;
    logic [3:0]  o_mask;
    rv_t r;
    cyc++;
    if (rst) model_reset();
    eg_a = m_run && a_req && (!b_req || !m_rr);
    eg_b = m_run && b_req && !eg_a;
    chk("a_gnt", a_gnt, eg_a);
    chk("b_gnt", b_gnt, eg_b);
    chk("init_done", init_done, m_run);
    case (e_mode)
      0: begin
        chk("rst_csb", sram_csb0, 1); chk("rst_web", sram_web0, 1);
        chk("rst_wmask", sram_wmask0, 0); chk("rst_addr", sram_addr0, 0);
        chk("rst_din", sram_din0, 0);
      end
      1: begin chk("idle_csb", sram_csb0, 1); chk("idle_web", sram_web0, 1); end
      2: begin
        chk("wr_csb", sram_csb0, 0); chk("wr_web", sram_web0, 0);
        chk("wr_addr", sram_addr0, e_addr); chk("wr_mask", sram_wmask0, e_mask);
        chk("wr_din", sram_din0, e_din);
      end
      default: begin
        chk("rd_csb", sram_csb0, 0); chk("rd_web", sram_web0, 1);
        chk("rd_addr", sram_addr0, e_addr);
      end
    endcase
    exp_rva = 0; exp_rvb = 0; exp_rd = '0;
    if (rvq.size() > 0 && rvq[0].due == cyc) begin
      r = rvq.pop_front();
      exp_rva = !r.owner; exp_rvb = r.owner; exp_rd = r.data;
    end
    chk("a_rvalid", a_rvalid, exp_rva);
    chk("b_rvalid", b_rvalid, exp_rvb);
    if (exp_rva) chk("a_rdata", a_rdata, exp_rd);
    if (exp_rvb) chk("b_rdata", b_rdata, exp_rd);

    // Predict the command the coming edge puts on the pins.
    a_acc_m = 0; b_acc_m = 0;
    if (!rst) begin
      if (!m_run) begin
        e_mode = 2; e_addr = 9'(m_init_cnt); e_mask = 4'hF; e_din = INIT_VALUE;
        mem_m[m_init_cnt] = INIT_VALUE;
        m_init_cnt++;
        if (m_init_cnt == DEPTH) m_run = 1;
      end else if (eg_a || eg_b) begin
        a_acc_m = eg_a; b_acc_m = eg_b;
        m_rr    = eg_a;
        o_we   = eg_a ? a_we : b_we;     o_addr = eg_a ? a_addr : b_addr;
        o_mask = eg_a ? a_wmask : b_wmask; o_data = eg_a ? a_wdata : b_wdata;
        e_addr = o_addr;
        if (o_we) begin
          e_mode = 2; e_mask = o_mask; e_din = o_data;
          for (int i = 0; i < 4; i++)
            if (o_mask[i]) mem_m[o_addr][8*i +: 8] = o_data[8*i +: 8];
        end else begin
          e_mode = 3;
          rvq.push_back('{cyc + 2, eg_b, mem_m[o_addr]});
        end
      end else begin
        e_mode = 1;
      end
    end
  end

  // Stimulus
  task automatic step();
    @(posedge clk0);
    #2;
  endtask

  task automatic issue(input bit who, input bit we, input logic [3:0] mask,
                       input logic [8:0] addr, input logic [31:0] data);
    int  n   = 0;
    bit  acc = 0;
    if (!who) begin a_req = 1; a_we = we; a_wmask = mask; a_addr = addr; a_wdata = data; end
    else      begin b_req = 1; b_we = we; b_wmask = mask; b_addr = addr; b_wdata = data; end
    while (!acc && n < 20) begin
      step();
      n++;
      acc = who ? b_acc_m : a_acc_m;
    end
    chk("accept_in_time", acc, 1);
    if (!who) a_req = 0; else b_req = 0;
  endtask

  task automatic read_check(input bit who, input logic [8:0] addr, input logic [31:0] exp,
                            input string name);
    issue(who, 1'b0, 4'h0, addr, 32'h0);
    step();
    chk({name, "_rvalid"}, who ? b_rvalid : a_rvalid, 1);
    chk({name, "_other_rvalid"}, who ? a_rvalid : b_rvalid, 0);
    chk({name, "_rdata"}, who ? b_rdata : a_rdata, exp);
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 600) begin
      step();
      n++;
    end
    chk(name, n, 512);
  endtask

  task automatic traffic(input int n, input int pct, input bit check_alt);
    int last = -1;
    int acc  = 0;
    for (int i = 0; i < n; i++) begin
      if (!a_req || a_acc_m) begin
        a_req = ($urandom_range(99) < pct); a_we = 1'($urandom_range(1));
        a_wmask = 4'($urandom_range(15)); a_addr = 9'($urandom_range(15)); a_wdata = $urandom;
      end
      if (!b_req || b_acc_m) begin
        b_req = ($urandom_range(99) < pct); b_we = 1'($urandom_range(1));
        b_wmask = 4'($urandom_range(15)); b_addr = 9'($urandom_range(15)); b_wdata = $urandom;
      end
      step();
      if (a_acc_m || b_acc_m) begin
        if (check_alt && last >= 0) chk("t3_alternate", 32'(b_acc_m), 32'(1 - last));
        last = int'(b_acc_m);
        acc++;
      end
    end
    a_req = 0; b_req = 0;
    if (check_alt) chk("t3_one_per_cycle", acc, n);
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mem2[i] = 32'hC0DE0000 | 32'(i);
    rst = 1; rst2 = 1; a_req2 = 0; b_req2 = 0;
    a_req = 0; a_we = 0; a_wmask = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_wmask = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(posedge clk0);
    #2;
    rst = 0;

    // Initialise pass; requests held throughout must never be granted.
    a_req = 1; b_req = 1;
    wait_init("t1_init_cycles");
    a_req = 0; b_req = 0;
    read_check(1'b0, 9'd511, 32'h0, "t1_rd511");

    // Write then read on the next cycle.
    issue(1'b0, 1'b1, 4'hF, 9'h010, 32'hDEADBEEF);
    read_check(1'b0, 9'h010, 32'hDEADBEEF, "t2_rd");

    // Byte-masked overwrite.
    issue(1'b0, 1'b1, 4'hF, 9'd5, 32'h11223344);
    issue(1'b1, 1'b1, 4'b0101, 9'd5, 32'hAABBCCDD);
    read_check(1'b1, 9'd5, 32'h11BB33DD, "t4_rd");

    // Both requesters busy every cycle.
    traffic(8, 100, 1'b1);
    repeat (3) step();

    // Reset with a read in flight, then again partway through the initialise pass.
    issue(1'b0, 1'b0, 4'h0, 9'd7, 32'h0);
    rst = 1;
    step();
    rst = 0;
    n = 0;
    while (m_init_cnt < 200 && n < 600) begin
      step();
      n++;
    end
    chk("t5_reach_200", m_init_cnt, 200);
    rst = 1;
    step();
    rst = 0;
    wait_init("t5_init_cycles");

    traffic(400, 70, 1'b0);
    repeat (4) step();

    // Instance without the initialise pass.
    rst2 = 0; a_req2 = 1;
    @(negedge clk0);
    chk("t6_done_before", init_done2, 0);
    chk("t6_gnt_before", a_gnt2, 0);
    step();
    @(negedge clk0);
    chk("t6_done_after", init_done2, 1);
    chk("t6_gnt_run", a_gnt2, 1);
    chk("t6_no_cmd", csb2, 1);
    step();
    a_req2 = 0;
    @(negedge clk0);
    chk("t6_rd_csb", csb2, 0);
    chk("t6_rd_web", web2, 1);
    chk("t6_rd_addr", addr2, 3);
    chk("t6_rvalid_early", a_rvalid2, 0);
    step();
    @(negedge clk0);
    chk("t6_rvalid", a_rvalid2, 1);
    chk("t6_b_rvalid", b_rvalid2, 0);
    chk("t6_rdata", a_rdata2, 32'hC0DE0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
